// File: rtl/rts_ctrl_pkg.sv
// Shared control definitions for the real-time solver step scheduler.
// Holds the sequencer FSM encoding and the minimum step period.
package rts_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StWait  = 2'd3
  } seq_state_e;

  localparam int unsigned MIN_PERIOD = 4;

  function automatic logic state_is_busy(input seq_state_e state);
    return (state == StStart) || (state == StRun);
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control/status bundle between the step sequencer (slave) and its controller
// and solver units (master).
interface step_sequencer_if #(
  parameter int unsigned N_UNITS = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned STEP_W  = 32
) ();

  logic               en;
  logic [CNT_W-1:0]   step_period;
  logic [N_UNITS-1:0] unit_mask;
  logic [N_UNITS-1:0] done_in;
  logic [N_UNITS-1:0] start_out;
  logic               step_end;
  logic               overrun;
  logic               overrun_flag;
  logic               busy;
  logic [STEP_W-1:0]  step_count;
  logic [STEP_W-1:0]  overrun_count;

  modport master (
    output en, step_period, unit_mask, done_in,
    input  start_out, step_end, overrun, overrun_flag, busy, step_count, overrun_count
  );

  modport slave (
    input  en, step_period, unit_mask, done_in,
    output start_out, step_end, overrun, overrun_flag, busy, step_count, overrun_count
  );

endinterface

// File: rtl/step_period_timer.sv
// Step period counter: restarts at 0 on entry to START, latches the clamped period
// during START and flags the last cycle of each step.
module step_period_timer
  import rts_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_latch,
  input  logic [CNT_W-1:0] i_step_period,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] w_per_clamped;

  always_comb begin
    w_per_clamped = i_step_period;
    if (i_step_period < CNT_W'(MIN_PERIOD)) begin
      w_per_clamped = CNT_W'(MIN_PERIOD);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_per <= CNT_W'(MIN_PERIOD);
    end else begin
      if (i_load) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_latch) begin
        r_per <= w_per_clamped;
      end
    end
  end

  assign o_tick = (r_cnt == (r_per - CNT_W'(1)));

endmodule

// File: rtl/step_sequencer.sv
// Time-step scheduler: pulses start to all enabled solver units each step, gathers
// their done pulses into sticky flags and reports step completion or overrun.
module step_sequencer
  import rts_ctrl_pkg::*;
#(
  parameter int unsigned N_UNITS = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned STEP_W  = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  step_sequencer_if.slave  io_seq
);

  seq_state_e r_state;
  seq_state_e w_state_d;

  logic [N_UNITS-1:0] r_flags;
  logic [N_UNITS-1:0] r_mask;
  logic [N_UNITS-1:0] w_flags_or;
  logic [N_UNITS-1:0] w_start_out;
  logic               w_all_done;
  logic               w_tick;
  logic               w_busy;
  logic               w_step_end_d;
  logic               w_overrun_d;

  logic               r_step_end;
  logic               r_overrun;
  logic               r_overrun_flag;
  logic [STEP_W-1:0]  r_step_count;
  logic [STEP_W-1:0]  r_overrun_count;

  step_period_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_load        (w_state_d == StStart),
    .i_latch       (r_state == StStart),
    .i_step_period (io_seq.step_period),
    .o_tick        (w_tick)
  );

  // Current-cycle done pulses count immediately; masked units always read as done.
  assign w_flags_or = r_flags | io_seq.done_in;
  assign w_all_done = &(w_flags_or | ~r_mask);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if ((r_state != StIdle) && !io_seq.en) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (io_seq.en) begin
            w_state_d = StStart;
          end
        end
        StStart: begin
          w_state_d = StRun;
        end
        StRun: begin
          if (w_all_done) begin
            w_state_d = w_tick ? StStart : StWait;
          end else if (w_tick) begin
            w_state_d = StStart;
          end
        end
        StWait: begin
          if (w_tick) begin
            w_state_d = StStart;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    w_start_out  = '0;
    w_step_end_d = 1'b0;
    w_overrun_d  = 1'b0;
    w_busy       = state_is_busy(r_state);
    if (r_state == StStart) begin
      w_start_out = io_seq.unit_mask;
    end
    // Completion beats overrun when the last done lands on the tick cycle.
    if ((r_state == StRun) && io_seq.en) begin
      w_step_end_d = w_all_done;
      w_overrun_d  = w_tick & ~w_all_done;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flags         <= '0;
      r_mask          <= '0;
      r_step_end      <= 1'b0;
      r_overrun       <= 1'b0;
      r_overrun_flag  <= 1'b0;
      r_step_count    <= '0;
      r_overrun_count <= '0;
    end else begin
      r_step_end <= w_step_end_d;
      r_overrun  <= w_overrun_d;
      if (w_step_end_d) begin
        r_step_count <= r_step_count + STEP_W'(1);
      end
      if (w_overrun_d) begin
        r_overrun_count <= r_overrun_count + STEP_W'(1);
        r_overrun_flag  <= 1'b1;
      end
      if (r_state == StStart) begin
        r_mask <= io_seq.unit_mask;
      end
      if ((w_state_d == StIdle) || (r_state == StStart)) begin
        r_flags <= '0;
      end else if (r_state == StRun) begin
        r_flags <= w_flags_or;
      end
    end
  end

  assign io_seq.start_out     = w_start_out;
  assign io_seq.busy          = w_busy;
  assign io_seq.step_end      = r_step_end;
  assign io_seq.overrun       = r_overrun;
  assign io_seq.overrun_flag  = r_overrun_flag;
  assign io_seq.step_count    = r_step_count;
  assign io_seq.overrun_count = r_overrun_count;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a step-level timing model predicts start,
// step_end and overrun events by cycle; a negedge monitor compares what appears.
module tb_step_sequencer;

  localparam int unsigned N  = 5;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 32;
  localparam int NEVER = 100000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  step_sequencer_if #(.N_UNITS(N), .CNT_W(CW), .STEP_W(SW)) bus ();

  step_sequencer #(.N_UNITS(N), .CNT_W(CW), .STEP_W(SW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_seq (bus)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] start;
    logic         se;
    logic         ov;
  } ev_t;

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_steps = 0;
  int   exp_ovr = 0;
  logic exp_flag = 1'b0;
  bit   mon_en = 1'b0;
  int   d_off[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Events landing in the same cycle are merged into one record.
  function automatic void push_ev(int c, logic [N-1:0] s, logic se, logic ov);
    ev_t e;
    if (s == '0 && !se && !ov) return;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == c) begin
      e = exp_q.pop_back();
      e.start = e.start | s;
      e.se    = e.se | se;
      e.ov    = e.ov | ov;
    end else begin
      e.cyc = c; e.start = s; e.se = se; e.ov = ov;
    end
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en && (bus.start_out != '0 || bus.step_end || bus.overrun)) begin
      check("end_ovr_exclusive", 64'(bus.step_end & bus.overrun), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 64'({bus.start_out, bus.step_end, bus.overrun}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        check("start_out", 64'(bus.start_out), 64'(e.start));
        check("step_end", 64'(bus.step_end), 64'(e.se));
        check("overrun", 64'(bus.overrun), 64'(e.ov));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_plan(input int a, input int b, input int c, input int d, input int e);
    d_off[0] = a; d_off[1] = b; d_off[2] = c; d_off[3] = d; d_off[4] = e;
  endtask

  function automatic logic [N-1:0] gen_done(int o, logic [N-1:0] mask, bit noisy);
    logic [N-1:0] v = '0;
    for (int u = 0; u < N; u++) begin
      if (!mask[u] || o == 0) v[u] = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      else if (o == d_off[u]) v[u] = 1'b1;
      else if (o > d_off[u])  v[u] = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    return v;
  endfunction

  // Runs enable for len cycles, then drops en (or pulses rst) and checks the idle state.
  task automatic run_episode(input int per, input logic [N-1:0] mask, input int len,
                             input bit random_plan, input bit abort_rst);
    int pe, s, cur, ta, f;
    pe = (per < 4) ? 4 : per;
    next_cycle();
    bus.step_period = CW'(per);
    bus.unit_mask   = mask;
    bus.en          = 1'b1;
    s   = cyc + 1;
    cur = s;
    ta  = cyc + len;
    forever begin
      next_cycle();
      if (cyc == s) begin
        if (random_plan) begin
          for (int u = 0; u < N; u++)
            d_off[u] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, pe + 2));
        end
        f = 1;
        for (int u = 0; u < N; u++) if (mask[u] && d_off[u] > f) f = d_off[u];
        push_ev(s, mask, 1'b0, 1'b0);
        if (f <= pe - 1) begin
          if (s + f + 1 <= ta) begin
            push_ev(s + f + 1, '0, 1'b1, 1'b0);
            exp_steps++;
          end
        end else if (s + pe <= ta) begin
          push_ev(s + pe, '0, 1'b0, 1'b1);
          exp_ovr++;
          exp_flag = 1'b1;
        end
        cur = s;
        s   = s + pe;
      end
      if (cyc == ta) begin
        bus.done_in = '0;
        bus.en      = 1'b0;
        if (abort_rst) rst = 1'b1;
        break;
      end
      bus.done_in = gen_done(cyc - cur, mask, random_plan);
    end
    next_cycle();
    rst = 1'b0;
    if (abort_rst) begin
      exp_steps = 0;
      exp_ovr   = 0;
      exp_flag  = 1'b0;
    end
    check("idle_busy", 64'(bus.busy), 64'd0);
    repeat (2) next_cycle();
    check("step_count", 64'(bus.step_count), 64'(exp_steps));
    check("overrun_count", 64'(bus.overrun_count), 64'(exp_ovr));
    check("overrun_flag", 64'(bus.overrun_flag), 64'(exp_flag));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.en          = 1'b0;
    bus.step_period = CW'(20);
    bus.unit_mask   = 5'h1F;
    bus.done_in     = '0;
    repeat (3) next_cycle();
    check("rst_start_out", 64'(bus.start_out), 64'd0);
    check("rst_step_end", 64'(bus.step_end), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    check("rst_overrun_flag", 64'(bus.overrun_flag), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_step_count", 64'(bus.step_count), 64'd0);
    check("rst_overrun_count", 64'(bus.overrun_count), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    set_plan(3, 5, 7, 9, 11);         run_episode(20, 5'h1F, 25, 1'b0, 1'b0);
    set_plan(3, 5, 7, 9, NEVER);      run_episode(20, 5'h1F, 22, 1'b0, 1'b0);
    set_plan(3, 5, 7, 9, 19);         run_episode(20, 5'h1F, 45, 1'b0, 1'b0);
    set_plan(2, 4, NEVER, NEVER, NEVER); run_episode(20, 5'h03, 30, 1'b0, 1'b0);
    set_plan(NEVER, NEVER, NEVER, NEVER, NEVER); run_episode(20, 5'h00, 50, 1'b0, 1'b0);
    set_plan(1, 1, 1, 1, 1);          run_episode(2, 5'h1F, 17, 1'b0, 1'b0);
    set_plan(3, 5, 7, 9, 11);         run_episode(20, 5'h1F, 8, 1'b0, 1'b0);
    set_plan(3, 5, 7, 9, NEVER);      run_episode(20, 5'h1F, 30, 1'b0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      run_episode(int'($urandom_range(1, 12)), N'($urandom_range(0, 31)),
                  int'($urandom_range(5, 60)), 1'b1, ($urandom_range(0, 7) == 0));
    end

    repeat (3) next_cycle();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
